// File: rtl/synth_note_scheduler.sv
// rtl/synth_note_scheduler.sv - note scheduler: mono lowest-key priority or up-arpeggio
//
// Turns a polyphonic key bitmap into one registered note index per cycle.
//   clk          system clock
//   rst          synchronous active-high reset
//   en           block enable; 0 forces idle and clears note/counter
//   keys         synchronized key levels, 1 = held, index 0 = lowest pitch
//   mode         0 = mono lowest-held, 1 = arpeggio up with wrap
//   note         note index to the oscillator
//   note_valid   1 while the oscillator should sound (state != IDLE)
//   note_strobe  one-cycle pulse when note is loaded with a sounding value
module synth_note_scheduler #(
    parameter int NUM_KEYS   = 16,
    parameter int STEP_TICKS = 1_000_000,
    parameter int CNT_W      = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_KEYS-1:0]         keys,
    input  logic                        mode,
    output logic [$clog2(NUM_KEYS)-1:0] note,
    output logic                        note_valid,
    output logic                        note_strobe
);

    localparam int NW = $clog2(NUM_KEYS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MONO = 2'd1,
        S_ARP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [NW-1:0]    note_q, note_d;
    logic             valid_q, valid_d;
    logic             strobe_q, strobe_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic          any_key;
    logic [NW-1:0] low_idx;
    logic [NW-1:0] next_idx;
    logic          step_done;

    // Descending scans so the last hit is the smallest qualifying index.
    // next_idx falls back to low_idx when nothing is held above note_q (wrap).
    always_comb begin
        any_key  = |keys;
        low_idx  = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keys[i]) begin
                low_idx = NW'(i);
            end
        end
        next_idx = low_idx;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keys[i] && (NW'(i) > note_q)) begin
                next_idx = NW'(i);
            end
        end
    end

    assign step_done = (cnt_q == CNT_W'(STEP_TICKS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            note_q   <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic; key release outranks mode changes and step advance.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (any_key) state_d = mode ? S_ARP : S_MONO;
                S_MONO: begin
                    if (!any_key)  state_d = S_IDLE;
                    else if (mode) state_d = S_ARP;
                end
                S_ARP: begin
                    if (!any_key)   state_d = S_IDLE;
                    else if (!mode) state_d = S_MONO;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        note_d   = note_q;
        strobe_d = 1'b0;
        cnt_d    = cnt_q;
        valid_d  = (state_d != S_IDLE);
        if (!en) begin
            note_d = '0;
            cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_key) begin
                        note_d   = low_idx;
                        strobe_d = 1'b1;
                        cnt_d    = '0;
                    end
                end
                S_MONO: begin
                    if (any_key) begin
                        note_d = low_idx;
                        if (mode) begin
                            // Entering ARP always strobes and restarts the step timer.
                            strobe_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            strobe_d = (low_idx != note_q);
                        end
                    end
                end
                S_ARP: begin
                    if (!any_key) begin
                        cnt_d = '0;
                    end else if (!mode) begin
                        note_d   = low_idx;
                        strobe_d = (low_idx != note_q);
                        cnt_d    = '0;
                    end else if (step_done) begin
                        // Strobe even when next_idx equals note_q (single key held).
                        note_d   = next_idx;
                        strobe_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    note_d = '0;
                    cnt_d  = '0;
                end
            endcase
        end
    end

    assign note        = note_q;
    assign note_valid  = valid_q;
    assign note_strobe = strobe_q;

endmodule

// File: tb/tb_synth_note_scheduler.sv
// tb/tb_synth_note_scheduler.sv - self-checking bench for synth_note_scheduler
module tb_synth_note_scheduler;

    localparam int NK   = 16;
    localparam int STEP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic [NK-1:0] keys = '0;
    logic          mode = 1'b0;
    logic [3:0]    note;
    logic          note_valid;
    logic          note_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the oscillator should be hearing.
    bit m_valid  = 0;
    int m_note   = 0;
    bit m_strobe = 0;
    bit m_arp    = 0;
    int m_age    = 0;   // cycles spent in the current arpeggio step

    synth_note_scheduler #(
        .NUM_KEYS  (NK),
        .STEP_TICKS(STEP),
        .CNT_W     (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .keys       (keys),
        .mode       (mode),
        .note       (note),
        .note_valid (note_valid),
        .note_strobe(note_strobe)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input logic [NK-1:0] k);
        for (int i = 0; i < NK; i++) if (k[i]) return i;
        return 0;
    endfunction

    function automatic int above(input logic [NK-1:0] k, input int c);
        for (int i = c + 1; i < NK; i++) if (k[i]) return i;
        return lowest(k);
    endfunction

    // Apply one clock edge of the specified behaviour to the reference state.
    task automatic model_edge();
        int prev;
        if (rst || !en) begin
            m_valid = 0; m_note = 0; m_strobe = 0; m_arp = 0; m_age = 0;
        end else if (!m_valid) begin
            m_strobe = 0;
            if (keys != 0) begin
                m_valid = 1; m_note = lowest(keys); m_strobe = 1;
                m_arp = mode; m_age = 0;
            end
        end else if (keys == 0) begin
            m_valid = 0; m_strobe = 0; m_arp = 0;
        end else if (mode && !m_arp) begin
            m_arp = 1; m_age = 0; m_note = lowest(keys); m_strobe = 1;
        end else if (!mode) begin
            prev = m_note; m_arp = 0;
            m_note = lowest(keys);
            m_strobe = (m_note != prev);
        end else begin
            m_age++;
            m_strobe = 0;
            if (m_age == STEP) begin
                m_age = 0; m_note = above(keys, m_note); m_strobe = 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: advance model, clock the DUT, sample 1 time unit later.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("valid", 32'(note_valid), 32'(m_valid));
        check("note", 32'(note), 32'(m_note));
        check("strobe", 32'(note_strobe), 32'(m_strobe));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int arp_seq[5] = '{0, 4, 15, 0, 4};

    initial begin
        // Reset with every key held
        rst = 1; en = 1; mode = 0; keys = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_valid", 32'(note_valid), 32'd0);
            check("rst_note", 32'(note), 32'd0);
            check("rst_strobe", 32'(note_strobe), 32'd0);
        end
        rst = 0;
        tick();
        check("rel_valid", 32'(note_valid), 32'd1);
        check("rel_note", 32'(note), 32'd0);
        check("rel_strobe", 32'(note_strobe), 32'd1);
        keys = 0; tick();

        // Mono priority
        mode = 0; keys = 16'h0120; tick();
        check("mono_low", 32'(note), 32'd5);
        tick();
        keys = 16'h0100; tick();
        check("mono_move", 32'(note), 32'd8);
        check("mono_strobe", 32'(note_strobe), 32'd1);
        tick();
        check("mono_nostrobe", 32'(note_strobe), 32'd0);
        keys = 0; tick();
        check("mono_off", 32'(note_valid), 32'd0);
        check("mono_hold", 32'(note), 32'd8);

        // Arpeggio wrap 0,4,15,0,4
        mode = 1; keys = 16'h8011;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("arp_seq", 32'(note), 32'(arp_seq[c / STEP]));
            check("arp_strobe", 32'(note_strobe), 32'((c % STEP) == 0));
        end
        keys = 0; tick();

        // Mid-step release of the sounding key
        keys = 16'h0006; tick();
        check("mid_start", 32'(note), 32'd1);
        keys = 16'h0004;
        ticks(2);
        tick();
        check("mid_hold", 32'(note), 32'd1);
        tick();
        check("mid_adv", 32'(note), 32'd2);
        check("mid_adv_strobe", 32'(note_strobe), 32'd1);
        ticks(3);
        tick();
        check("mid_again", 32'(note), 32'd2);
        check("mid_again_strobe", 32'(note_strobe), 32'd1);
        keys = 0; tick();

        // Mode switch and enable
        keys = 16'h0014; ticks(5);
        check("sw_arp4", 32'(note), 32'd4);
        mode = 0; tick();
        check("sw_mono", 32'(note), 32'd2);
        check("sw_strobe", 32'(note_strobe), 32'd1);
        en = 0; tick();
        check("en_off", 32'(note_valid), 32'd0);
        en = 1; tick();
        check("en_on_valid", 32'(note_valid), 32'd1);
        check("en_on_note", 32'(note), 32'd2);
        keys = 0; tick();

        // Single-key arpeggio
        mode = 1; keys = 16'h0400;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("single_note", 32'(note), 32'd10);
            check("single_strobe", 32'(note_strobe), 32'((c % STEP) == 0));
        end

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       keys = '0;
                    1:       keys = NK'(1) << $urandom_range(0, NK - 1);
                    default: keys = NK'($urandom);
                endcase
            end
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            en  = ($urandom_range(0, 49) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/synth_note_scheduler.md
# synth_note_scheduler

Note scheduler sitting between the synchronized key inputs and `silly_synthesizer`'s tone generator. It arbitrates among the 16 key lines and presents exactly one note index per cycle to the oscillator. It supports two modes:
- **Mono:** lowest-index held key wins.
- **Arpeggio:** steps upward through all held keys at a fixed tempo, wrapping around.

It converts a polyphonic key bitmap into a monophonic, time-sequenced note stream.

## Interface
Parameters:
- `NUM_KEYS`, 16: number of key inputs. Index 0 is the lowest pitch.
- `STEP_TICKS`, 1_000_000: clock cycles per arpeggio step. Must be ≥ 2.
- `CNT_W`, 20: tick counter width. Must satisfy 2^CNT_W ≥ STEP_TICKS.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: synchronous, active-high reset.
- `en`, input, 1: block enable (chip selected). 0 forces idle.
- `keys`, input, NUM_KEYS: already-synchronized key levels, 1 = held.
- `mode`, input, 1: 0 = mono lowest-priority, 1 = arpeggio up.
- `note`, output, $clog2(NUM_KEYS): note index driven to the oscillator.
- `note_valid`, output, 1: 1 = oscillator sounds `note`; 0 = silence.
- `note_strobe`, output, 1: one-cycle pulse whenever `note` is loaded with valid=1.

## Operation
- **Reset / `en`=0:** `rst`=1 or `en`=0 at a clock edge sets all of the following:
  - state=IDLE, `note`=0, `note_valid`=0, `note_strobe`=0, tick counter=0.
  - `en`=0 takes precedence over all key activity.
- **Lowest-held function:** `low` is the smallest index i with `keys[i]`=1.
- **Next-above function:** `next(c)` is the smallest held index greater than c. If no such index exists, it is `low` (wrap-around).

States:
- **IDLE:** `note_valid`=0.
  - If any key is held and `mode`=0 → MONO; load `note`=`low`.
  - If any key is held and `mode`=1 → ARP; load `note`=`low` and clear the counter.
- **MONO:** every cycle, `note`←`low`.
  - `note_strobe` pulses only when the loaded value differs from the current `note`.
  - No keys held → IDLE.
  - `mode`=1 → ARP; load `note`=`low`, clear the counter, strobe.
- **ARP:** the counter increments each cycle.
  - When the counter equals STEP_TICKS-1: `note`←`next(note)`, counter←0, strobe. The strobe fires even if the value is unchanged, e.g. only one key held.
  - Releasing the currently sounding key mid-step does not change `note` until the step boundary.
  - No keys held → IDLE.
  - `mode`=0 → MONO; load `low` with strobe-if-changed.
- **Exit priority:** all-keys-released is evaluated before the step advance in the same cycle.
- **`note_valid`:** equals 1 exactly when state ≠ IDLE (registered).

## Timing
- All outputs are registered.
- A key bitmap change is reflected on `note` one cycle later (latency 1) in IDLE and MONO.
- **IDLE exit:** in the cycle after the first key press, `note_valid`=1, `note_strobe`=1, `note`=`low`.
- **Arpeggio cadence:** steps occur every STEP_TICKS cycles, measured from ARP entry. The first advance happens STEP_TICKS cycles after the cycle `note_valid` rose.
- **IDLE entry:** all keys released → `note_valid`=0 the next cycle. `note` holds its last value and `note_strobe`=0.
- **Mode toggle:** a toggle on any cycle takes effect at the next edge. The counter restarts on every entry to ARP.
- **Reset mid-step:** `rst` mid-arpeggio discards the counter. After release, the block restarts from IDLE.
- **Counter width:** the counter never exceeds STEP_TICKS-1; no overflow is possible given the `CNT_W` constraint.

## Test plan
All scenarios use STEP_TICKS=4.
- **Reset:** hold `rst` 3 cycles with `keys`=16'hFFFF → `note_valid`=0, `note`=0, `note_strobe`=0 throughout. The cycle after release: `note_valid`=1, `note`=0, strobe=1.
- **Mono priority:** `mode`=0; `keys`=16'h0120 → `note`=5. Then `keys`=16'h0100 → `note`=8 one cycle later with a single strobe. Then `keys`=0 → `note_valid`=0 the next cycle.
- **Arpeggio wrap:** `mode`=1; `keys`=16'h8011 → `note` sequence 0,4,15,0,4. Each value holds exactly 4 cycles, with one strobe per step.
- **Mid-step release:** `mode`=1, `keys`=16'h0006, `note`=1. Release key 1 one cycle into the step → `note` stays 1 until the boundary, then becomes 2, then 2 again after 4 more cycles with a strobe.
- **Mode switch and enable:**
  - In ARP at `note`=4 with `keys`=16'h0014, set `mode`=0 → `note`=2 the next cycle with a strobe.
  - Then drop `en` → `note_valid`=0 the next cycle.
  - Raise `en` → `note_valid`=1 and `note`=2 one cycle later.
- **Single key arpeggio:** `mode`=1, `keys`=16'h0400 → `note`=10 constant, with `note_strobe` every 4 cycles.
